// File: rtl/snow64_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : snow64_alu_arbiter
//  Description : Round-robin arbiter that shares a single combinational
//                Snow64 ALU among NUM_REQ requesters. A request is captured
//                in an issue register that drives the ALU. The ALU output is
//                captured in a result register and returned to the
//                requester with valid/ready handshaking.
//  Revision    : 1.0 - initial release
// ============================================================================
module snow64_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OPER_W  = 4,
    parameter int TSZ_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPER_W-1:0] req_oper,
    input  logic [NUM_REQ*TSZ_W-1:0]  req_type_size,
    input  logic [NUM_REQ*64-1:0]     req_a,
    input  logic [NUM_REQ*64-1:0]     req_b,
    output logic [OPER_W-1:0]         alu_oper,
    output logic [TSZ_W-1:0]          alu_type_size,
    output logic [63:0]               alu_a,
    output logic [63:0]               alu_b,
    input  logic [63:0]               alu_result,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [63:0]               resp_data,
    input  logic                      resp_ready,
    output logic                      busy
);

    // Issue stage: holds the operation currently presented to the ALU
    logic              r_issue_v;
    logic [ID_W-1:0]   r_issue_id;
    logic [OPER_W-1:0] r_alu_oper;
    logic [TSZ_W-1:0]  r_alu_type_size;
    logic [63:0]       r_alu_a;
    logic [63:0]       r_alu_b;

    // Result stage: holds the ALU output until the consumer takes it
    logic              r_resp_valid;
    logic [ID_W-1:0]   r_resp_id;
    logic [63:0]       r_resp_data;

    // Requester that gets first priority on the next scan
    logic [ID_W-1:0]   r_rr_ptr;

    logic              w_res_adv;
    logic              w_iss_free;
    logic              w_issue_adv;
    logic              w_grant_found;
    logic [ID_W-1:0]   w_grant_id;
    logic              w_accept;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [OPER_W-1:0] w_sel_oper;
    logic [TSZ_W-1:0]  w_sel_tsz;
    logic [63:0]       w_sel_a;
    logic [63:0]       w_sel_b;
    logic [ID_W-1:0]   w_rr_next;

    assign w_res_adv   = !r_resp_valid || resp_ready;
    assign w_iss_free  = !r_issue_v || w_res_adv;
    assign w_issue_adv = r_issue_v && w_res_adv;
    assign w_accept    = w_grant_found && w_iss_free && !rst;

    // Round-robin scan from r_rr_ptr; walking downward lets the nearest hit win
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = idx[ID_W-1:0];
            end
        end
    end

    // One-hot accept toward the granted requester
    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_grant_id] = 1'b1;
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        w_sel_oper = '0;
        w_sel_tsz  = '0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_sel_oper = req_oper[i*OPER_W +: OPER_W];
                w_sel_tsz  = req_type_size[i*TSZ_W +: TSZ_W];
                w_sel_a    = req_a[i*64 +: 64];
                w_sel_b    = req_b[i*64 +: 64];
            end
        end
    end

    assign w_rr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

    // Pipeline registers: accept into issue, advance issue into result, retire
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_v       <= 1'b0;
            r_issue_id      <= '0;
            r_alu_oper      <= '0;
            r_alu_type_size <= '0;
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_id       <= '0;
            r_resp_data     <= '0;
            r_rr_ptr        <= '0;
        end else begin
            if (w_issue_adv) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_issue_id;
                r_resp_data  <= alu_result;
            end else if (resp_ready) begin
                r_resp_valid <= 1'b0;
            end

            // ALU inputs keep their last value when the issue stage empties
            if (w_accept) begin
                r_issue_v       <= 1'b1;
                r_issue_id      <= w_grant_id;
                r_alu_oper      <= w_sel_oper;
                r_alu_type_size <= w_sel_tsz;
                r_alu_a         <= w_sel_a;
                r_alu_b         <= w_sel_b;
                r_rr_ptr        <= w_rr_next;
            end else if (w_issue_adv) begin
                r_issue_v <= 1'b0;
            end
        end
    end

    assign req_ready     = w_req_ready;
    assign alu_oper      = r_alu_oper;
    assign alu_type_size = r_alu_type_size;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign resp_valid    = r_resp_valid;
    assign resp_id       = r_resp_id;
    assign resp_data     = r_resp_data;
    assign busy          = r_issue_v || r_resp_valid;

endmodule
`default_nettype wire

// File: doc/snow64_alu_arbiter.md
Name: snow64_alu_arbiter

Overview:
- Shares one Snow64Alu instance (combinational, 64-bit, sliced 8/16/32/64 lanes) among NUM_REQ requesters.
- Uses round-robin arbitration and a two-stage registered pipeline: an issue register drives the ALU, and a result register captures its output.
- Returns each result to its originator with valid/ready backpressure.
- Sits between the per-lane operand fetch logic and the shared ALU datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width; equals clog2(NUM_REQ).
- OPER_W, 4, ALU operation code width.
- TSZ_W, 2, type size code width (TypSz8/16/32/64).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_oper  in  NUM_REQ*OPER_W  packed opcodes; requester i at [i*OPER_W +: OPER_W].
- req_type_size  in  NUM_REQ*TSZ_W  packed type sizes.
- req_a  in  NUM_REQ*64  packed operand A.
- req_b  in  NUM_REQ*64  packed operand B.
- alu_oper  out  OPER_W  to ALU, from issue register.
- alu_type_size  out  TSZ_W  to ALU, from issue register.
- alu_a  out  64  to ALU, from issue register.
- alu_b  out  64  to ALU, from issue register.
- alu_result  in  64  ALU data output, combinational from alu_* signals.
- resp_valid  out  1  result register holds a result.
- resp_id  out  ID_W  requester index owning the result.
- resp_data  out  64  result data.
- resp_ready  in  1  consumer accepts the result this cycle.
- busy  out  1  high when issue_v or resp_valid is set.

Behaviour:
- Reset: rst sampled at posedge clk. On reset:
  - issue_v=0, resp_valid=0, rr_ptr=0.
  - alu_oper/alu_type_size/alu_a/alu_b=0, resp_id=0, resp_data=0.
  - req_ready=0 during the cycle rst is high.
  - Reset mid-operation discards all in-flight work; no response is emitted for it.
- Stall terms:
  - res_adv = !resp_valid | resp_ready.
  - iss_free = !issue_v | res_adv.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit is g.
  - req_ready[g]=1 only if iss_free and rst=0; all other bits 0.
  - req_ready may depend combinationally on req_valid.
  - Requesters must hold their operands stable while valid and not ready.
- Accept (req_valid[g] & req_ready[g]):
  - Issue register loads g and the operands of g; issue_v=1.
  - rr_ptr becomes (g+1) mod NUM_REQ.
  - rr_ptr is unchanged on cycles with no accept.
- Issue to result:
  - If issue_v & res_adv: result register loads alu_result and issue id; resp_valid=1.
  - The issue register is cleared unless a new accept occurs in the same cycle, which refills it.
- Response:
  - resp_valid & resp_ready retires the result.
  - resp_valid clears unless the issue register advances in the same cycle, which gives back-to-back results.
- Latency: accept at edge N; resp_valid visible after edge N+1 (2 edges).
- Throughput: 1 op/cycle when resp_ready is held high.
- Full: issue_v=1 and resp_valid=1 with resp_ready=0 gives all req_ready=0; the issue and result registers hold; ALU inputs stay stable.
- Empty: no req_valid leaves issue_v clearing; alu_* hold their last values (not zeroed).
- Simultaneous events: retire, advance and accept in one cycle are all legal; no bubble, no loss.
- Ordering: responses return in accept order; only one op is ever in each stage.
- Width rules: operands pass unmodified; the ALU applies type_size slicing and carry chaining. The arbiter does not inspect opcodes; OpSlt and others are treated identically.

Test Plan:
- Reset: assert rst with req_valid=4'b1111 → req_ready=0, resp_valid=0, busy=0; after release the first grant goes to requester 0.
- Single op:
  - req 2, OpAdd, TypSz64, a=64'h1, b=64'hFFFF_FFFF_FFFF_FFFF; ALU model returns the sum.
  - Expected: resp_valid two edges after accept, resp_id=2, resp_data=64'h0.
- Round robin: req_valid=4'b1111 held, resp_ready=1 → grants 0,1,2,3,0 on consecutive cycles; resp_id follows the same sequence; one result per cycle.
- Backpressure:
  - resp_ready=0 with 3 requests pending → after 2 accepts all req_ready=0; resp_data and alu_a stable.
  - Raise resp_ready → remaining results drain in order with no duplicates.
- Simultaneous events: resp_valid=1, resp_ready=1, issue_v=1, new request → same edge retires, advances and accepts; busy stays 1; no bubble.
- Mid-operation reset: assert rst with issue_v=1 and resp_valid=1 → next cycle both are 0 and rr_ptr=0; the stale result never appears.
